// File: rtl/csp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csp_pkg
//  Description : Shared types for the bundled-data handshake channel:
//                protocol selector, input/output FSM state encodings and
//                the default data word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package csp_pkg;

    typedef enum logic {
        P2PhaseBD = 1'b0,
        P4PhaseBD = 1'b1
    } hs_protocol_e;

    typedef enum logic [0:0] {
        I_IDLE = 1'b0,
        I_ACK  = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        O_IDLE = 2'd0,
        O_REQ  = 2'd1,
        O_WAIT = 2'd2
    } out_state_e;

    localparam int CSP_DEFAULT_WIDTH = 11;

endpackage
`default_nettype wire

// File: rtl/channel_sync_bit.sv
`default_nettype none
// ============================================================================
//  Module      : sync_bit
//  Description : N-stage flop synchronizer for a single bit. STAGES = 0
//                passes the input straight through (already synchronous).
//  Ports       : clk  - clock
//                rst  - asynchronous active-high reset (flops clear to 0)
//                d    - bit to synchronize
//                q    - synchronized bit
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
            // Clock and reset have no load in pass-through mode.
            wire unused_clk_rst = clk ^ rst;
        end else begin : g_chain
            logic [STAGES-1:0] r_sync;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync[0] <= d;
                    for (int k = 1; k < STAGES; k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign q = r_sync[STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/channel.sv
`default_nettype none
// ============================================================================
//  Module      : channel
//  Description : Point-to-point bundled-data handshake channel with a
//                one-word buffer. 4-phase or 2-phase signalling on both
//                sides, selected by HS_PROTOCOL. All outputs registered.
//  Ports       : clk, rst          - clock, asynchronous active-high reset
//                in_req/in_ack     - producer handshake
//                in_data           - producer word (stable while pending)
//                out_req/out_ack   - consumer handshake
//                out_data          - buffered word
//                full              - buffer holds an unconsumed word
//                xfer_in/xfer_out  - one-cycle pulses per capture/consume
//  Revision    : 1.0 - initial release
// ============================================================================
module channel
    import csp_pkg::*;
#(
    parameter int           WIDTH       = CSP_DEFAULT_WIDTH,
    parameter hs_protocol_e HS_PROTOCOL = P4PhaseBD,
    parameter int           SYNC_STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_req,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ack,
    output logic             out_req,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ack,
    output logic             full,
    output logic             xfer_in,
    output logic             xfer_out
);

    localparam bit IS_4P = (HS_PROTOCOL == P4PhaseBD);

    logic       w_in_req;
    logic       w_out_ack;
    in_state_e  r_in_state,  w_in_state_nxt;
    out_state_e r_out_state, w_out_state_nxt;
    logic       w_in_ack_nxt;
    logic       w_out_req_nxt;
    logic       w_capture;
    logic       w_consume;
    logic       w_full_nxt;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_in_req (
        .clk (clk),
        .rst (rst),
        .d   (in_req),
        .q   (w_in_req)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_out_ack (
        .clk (clk),
        .rst (rst),
        .d   (out_ack),
        .q   (w_out_ack)
    );

    // Input side. Capture looks only at the registered full flag, so a word
    // consumed on this edge frees the buffer for the next edge, not this one.
    always_comb begin
        w_in_state_nxt = r_in_state;
        w_in_ack_nxt   = in_ack;
        w_capture      = 1'b0;
        if (IS_4P) begin
            case (r_in_state)
                I_IDLE: if (w_in_req && !full) begin
                    w_capture      = 1'b1;
                    w_in_ack_nxt   = 1'b1;
                    w_in_state_nxt = I_ACK;
                end
                I_ACK: if (!w_in_req) begin
                    w_in_ack_nxt   = 1'b0;
                    w_in_state_nxt = I_IDLE;
                end
                default: w_in_state_nxt = I_IDLE;
            endcase
        end else begin
            // 2-phase: a request is pending whenever the phases differ.
            if ((w_in_req != in_ack) && !full) begin
                w_capture    = 1'b1;
                w_in_ack_nxt = ~in_ack;
            end
        end
    end

    // Output side.
    always_comb begin
        w_out_state_nxt = r_out_state;
        w_out_req_nxt   = out_req;
        w_consume       = 1'b0;
        if (IS_4P) begin
            case (r_out_state)
                O_IDLE: if (full) begin
                    w_out_req_nxt   = 1'b1;
                    w_out_state_nxt = O_REQ;
                end
                O_REQ: if (w_out_ack) begin
                    w_out_req_nxt   = 1'b0;
                    w_consume       = 1'b1;
                    w_out_state_nxt = O_WAIT;
                end
                O_WAIT: if (!w_out_ack) begin
                    // Skip O_IDLE when a new word is already waiting.
                    if (full) begin
                        w_out_req_nxt   = 1'b1;
                        w_out_state_nxt = O_REQ;
                    end else begin
                        w_out_state_nxt = O_IDLE;
                    end
                end
                default: w_out_state_nxt = O_IDLE;
            endcase
        end else begin
            case (r_out_state)
                O_IDLE: if (full && (out_req == w_out_ack)) begin
                    w_out_req_nxt   = ~out_req;
                    w_out_state_nxt = O_REQ;
                end
                O_REQ: if (w_out_ack == out_req) begin
                    w_consume       = 1'b1;
                    w_out_state_nxt = O_IDLE;
                end
                default: w_out_state_nxt = O_IDLE;
            endcase
        end
    end

    // Set and clear never coincide: capture needs full=0, consume needs full=1.
    assign w_full_nxt = w_capture ? 1'b1 : (w_consume ? 1'b0 : full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_state  <= I_IDLE;
            r_out_state <= O_IDLE;
            in_ack      <= 1'b0;
            out_req     <= 1'b0;
            out_data    <= '0;
            full        <= 1'b0;
            xfer_in     <= 1'b0;
            xfer_out    <= 1'b0;
        end else begin
            r_in_state  <= w_in_state_nxt;
            r_out_state <= w_out_state_nxt;
            in_ack      <= w_in_ack_nxt;
            out_req     <= w_out_req_nxt;
            full        <= w_full_nxt;
            xfer_in     <= w_capture;
            xfer_out    <= w_consume;
            if (w_capture) begin
                out_data <= in_data;
            end
        end
    end

`ifndef SYNTHESIS
    // Producer must hold its request until it is acknowledged.
    a_in_req_hold: assert property (@(posedge clk) disable iff (rst)
        (IS_4P ? (r_in_state == I_IDLE && w_in_req) : (w_in_req != in_ack))
        |=> ((w_in_req == $past(w_in_req)) || (in_ack != $past(in_ack))));

    // Consumer must not acknowledge a request that was never issued.
    a_out_ack_valid: assert property (@(posedge clk) disable iff (rst)
        (r_out_state == O_IDLE) |-> (IS_4P ? !w_out_ack : (w_out_ack == out_req)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_channel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_channel
//  Description : Self-checking bench for channel. Three instances:
//                0 = 4-phase, no sync; 1 = 2-phase, no sync;
//                2 = 4-phase, 2 sync stages. Producer/consumer tasks drive
//                the handshakes; a word queue is the reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_channel;
    import csp_pkg::*;

    localparam int W     = 11;
    localparam int NI    = 3;
    localparam int BOUND = 300;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_req   [NI];
    logic         in_ack   [NI];
    logic         out_req  [NI];
    logic         out_ack  [NI];
    logic         full     [NI];
    logic         xfer_in  [NI];
    logic         xfer_out [NI];
    logic [W-1:0] in_data  [NI];
    logic [W-1:0] out_data [NI];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_xin  [NI];
    int n_xout [NI];
    int n_atg  [NI];
    int n_rtg  [NI];
    logic p_ack [NI];
    logic p_req [NI];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    channel #(.WIDTH(W), .HS_PROTOCOL(P4PhaseBD), .SYNC_STAGES(0)) u_dut_4p (
        .clk(clk), .rst(rst), .in_req(in_req[0]), .in_data(in_data[0]), .in_ack(in_ack[0]),
        .out_req(out_req[0]), .out_data(out_data[0]), .out_ack(out_ack[0]), .full(full[0]),
        .xfer_in(xfer_in[0]), .xfer_out(xfer_out[0]));

    channel #(.WIDTH(W), .HS_PROTOCOL(P2PhaseBD), .SYNC_STAGES(0)) u_dut_2p (
        .clk(clk), .rst(rst), .in_req(in_req[1]), .in_data(in_data[1]), .in_ack(in_ack[1]),
        .out_req(out_req[1]), .out_data(out_data[1]), .out_ack(out_ack[1]), .full(full[1]),
        .xfer_in(xfer_in[1]), .xfer_out(xfer_out[1]));

    channel #(.WIDTH(W), .HS_PROTOCOL(P4PhaseBD), .SYNC_STAGES(2)) u_dut_4p_s2 (
        .clk(clk), .rst(rst), .in_req(in_req[2]), .in_data(in_data[2]), .in_ack(in_ack[2]),
        .out_req(out_req[2]), .out_data(out_data[2]), .out_ack(out_ack[2]), .full(full[2]),
        .xfer_in(xfer_in[2]), .xfer_out(xfer_out[2]));

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (xfer_in[i])  n_xin[i]++;
            if (xfer_out[i]) n_xout[i]++;
            if (in_ack[i]  !== p_ack[i]) n_atg[i]++;
            if (out_req[i] !== p_req[i]) n_rtg[i]++;
            p_ack[i] = in_ack[i];
            p_req[i] = out_req[i];
        end
    end

    function automatic bit is_4p(int i);
        return i != 1;
    endfunction

    function automatic int stages(int i);
        return (i == 2) ? 2 : 0;
    endfunction

    function automatic logic issued(int i);
        return is_4p(i) ? out_req[i] : (out_req[i] != out_ack[i]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Producer: present a word, wait for the acknowledge, complete the handshake.
    task automatic produce(input int i, input logic [W-1:0] w, output int lat);
        int t;
        int k;
        in_data[i] = w;
        in_req[i]  = is_4p(i) ? 1'b1 : ~in_req[i];
        t = cyc;
        for (k = 0; k < BOUND && in_ack[i] !== in_req[i]; k++) @(negedge clk);
        lat = cyc - t;
        if (in_ack[i] !== in_req[i]) check("prod_ack_timeout", 64'(in_ack[i]), 64'(in_req[i]));
        if (is_4p(i)) begin
            in_req[i] = 1'b0;
            for (k = 0; k < BOUND && in_ack[i] !== 1'b0; k++) @(negedge clk);
            if (in_ack[i] !== 1'b0) check("prod_rtz_timeout", 64'(in_ack[i]), 64'd0);
        end
    endtask

    // Consumer: wait for a request, hold off dly cycles, acknowledge, wait for full to drop.
    task automatic consume(input int i, input int dly, output logic [W-1:0] w, output int lat);
        int t;
        int k;
        for (k = 0; k < BOUND && issued(i) !== 1'b1; k++) @(negedge clk);
        if (issued(i) !== 1'b1) check("cons_req_timeout", 64'(issued(i)), 64'd1);
        w = out_data[i];
        repeat (dly) @(negedge clk);
        out_ack[i] = is_4p(i) ? 1'b1 : out_req[i];
        t = cyc;
        for (k = 0; k < BOUND && full[i] !== 1'b0; k++) @(negedge clk);
        lat = cyc - t;
        if (full[i] !== 1'b0) check("cons_full_timeout", 64'(full[i]), 64'd0);
        if (is_4p(i)) out_ack[i] = 1'b0;
    endtask

    task automatic t_single(input int i);
        int li, lo, lr, t0, bi, bo, k;
        logic [W-1:0] w;
        bi = n_xin[i];
        bo = n_xout[i];
        lr = -1;
        fork
            produce(i, 11'h5A3, li);
            begin
                for (k = 0; k < BOUND && full[i] !== 1'b1; k++) @(negedge clk);
                t0 = cyc;
                for (k = 0; k < BOUND && issued(i) !== 1'b1; k++) @(negedge clk);
                lr = cyc - t0;
            end
        join
        check($sformatf("lat_in_ack[%0d]", i), 64'(li), 64'(1 + stages(i)));
        check($sformatf("lat_out_req[%0d]", i), 64'(lr), 64'd1);
        check($sformatf("single_data[%0d]", i), 64'(out_data[i]), 64'h5A3);
        consume(i, 2, w, lo);
        check($sformatf("single_word[%0d]", i), 64'(w), 64'h5A3);
        check($sformatf("lat_consume[%0d]", i), 64'(lo), 64'(1 + stages(i)));
        repeat (4) @(negedge clk);
        check($sformatf("single_xin[%0d]", i), 64'(n_xin[i] - bi), 64'd1);
        check($sformatf("single_xout[%0d]", i), 64'(n_xout[i] - bo), 64'd1);
    endtask

    task automatic t_backpressure(input int i);
        int li, li2, lo;
        logic [W-1:0] w;
        produce(i, 11'h001, li);
        fork
            produce(i, 11'h7FF, li2);
            begin
                repeat (12) @(negedge clk);
                check($sformatf("bp_no_ack[%0d]", i), 64'(in_ack[i] == in_req[i]), 64'd0);
                check($sformatf("bp_full[%0d]", i), 64'(full[i]), 64'd1);
                consume(i, 0, w, lo);
                check($sformatf("bp_word0[%0d]", i), 64'(w), 64'h001);
                consume(i, 1, w, lo);
                check($sformatf("bp_word1[%0d]", i), 64'(w), 64'h7FF);
            end
        join
        repeat (4) @(negedge clk);
    endtask

    task automatic t_stream(input int i);
        logic [W-1:0] q[$];
        logic [W-1:0] wp, wc, we;
        int li, lo, bi, bo;
        bi = n_xin[i];
        bo = n_xout[i];
        fork
            for (int n = 0; n < 16; n++) begin
                wp = W'($urandom);
                q.push_back(wp);
                produce(i, wp, li);
            end
            for (int n = 0; n < 16; n++) begin
                consume(i, $urandom_range(0, 5), wc, lo);
                we = (q.size() > 0) ? q.pop_front() : ~wc;
                check($sformatf("stream_word[%0d]", i), 64'(wc), 64'(we));
            end
        join
        repeat (6) @(negedge clk);
        check($sformatf("stream_xin[%0d]", i), 64'(n_xin[i] - bi), 64'd16);
        check($sformatf("stream_xout[%0d]", i), 64'(n_xout[i] - bo), 64'd16);
    endtask

    task automatic t_toggle(input int i);
        int li, lo, ba, br;
        logic [W-1:0] w;
        ba = n_atg[i];
        br = n_rtg[i];
        for (int n = 0; n < 4; n++) begin
            produce(i, W'(n), li);
            consume(i, 0, w, lo);
            check($sformatf("tg_word%0d", n), 64'(w), 64'(n));
        end
        repeat (4) @(negedge clk);
        check("tg_in_ack_toggles", 64'(n_atg[i] - ba), 64'd4);
        check("tg_out_req_toggles", 64'(n_rtg[i] - br), 64'd4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int li;
        for (int i = 0; i < NI; i++) begin
            in_req[i] = 1'b0; out_ack[i] = 1'b0; in_data[i] = '0;
            n_xin[i] = 0; n_xout[i] = 0; n_atg[i] = 0; n_rtg[i] = 0;
            p_ack[i] = 1'b0; p_req[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_in_ack[%0d]", i), 64'(in_ack[i]), 64'd0);
            check($sformatf("rst_out_req[%0d]", i), 64'(out_req[i]), 64'd0);
            check($sformatf("rst_full[%0d]", i), 64'(full[i]), 64'd0);
            check($sformatf("rst_out_data[%0d]", i), 64'(out_data[i]), 64'd0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NI; i++) begin
            t_single(i);
            t_backpressure(i);
            t_stream(i);
            if (i == 1) t_toggle(i);
        end

        // Fill every buffer, then assert reset between clock edges.
        for (int i = 0; i < NI; i++) produce(i, 11'h3C5, li);
        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("pre_rst_full[%0d]", i), 64'(full[i]), 64'd1);
        end
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("arst_in_ack[%0d]", i), 64'(in_ack[i]), 64'd0);
            check($sformatf("arst_out_req[%0d]", i), 64'(out_req[i]), 64'd0);
            check($sformatf("arst_full[%0d]", i), 64'(full[i]), 64'd0);
            check($sformatf("arst_out_data[%0d]", i), 64'(out_data[i]), 64'd0);
            in_req[i] = 1'b0;
            out_ack[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
